// File: rtl/bus_xfer_arbiter.sv
// Host-bus controller for NUM_CH accelerator FIFO ports: round-robin get path
// onto a registered valid/ready output, combinational routed put path.
module bus_xfer_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CH_W   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        ch_get_req_i,
  input  logic [NUM_CH-1:0]        ch_empty_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata_i,
  output logic [NUM_CH-1:0]        ch_pop_o,
  input  logic [NUM_CH-1:0]        ch_full_i,
  output logic [NUM_CH-1:0]        ch_push_o,
  output logic [DATA_W-1:0]        ch_wdata_o,
  output logic                     bus_out_valid_o,
  input  logic                     bus_out_ready_i,
  output logic [DATA_W-1:0]        bus_out_data_o,
  output logic [CH_W-1:0]          bus_out_ch_o,
  input  logic                     bus_in_valid_i,
  input  logic [CH_W-1:0]          bus_in_ch_i,
  input  logic [DATA_W-1:0]        bus_in_data_i,
  output logic                     bus_in_ready_o,
  output logic                     bad_ch_err_o
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                valid_q, valid_d;
  logic                bad_q, bad_d;

  logic [NUM_CH-1:0]   elig;
  logic [NUM_CH-1:0]   pop_c;
  logic [CH_W-1:0]     win;
  logic [DATA_W-1:0]   win_data;
  logic                ch_ok;
  logic                full_sel;

  assign elig = ch_get_req_i & ~ch_empty_i;

  // Rotating-priority search: lowest eligible index at or above rr_ptr, else lowest overall.
  always_comb begin
    logic [CH_W-1:0] win_lo, win_hi;
    logic            any_hi;
    int              rr_int;
    win_lo   = '0;
    win_hi   = '0;
    any_hi   = 1'b0;
    rr_int   = 32'(rr_ptr_q);
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_lo = CH_W'(i);
        if (i >= rr_int) begin
          win_hi = CH_W'(i);
          any_hi = 1'b1;
        end
      end
    end
    win      = any_hi ? win_hi : win_lo;
    win_data = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (CH_W'(i) == win) win_data = ch_rdata_i[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      data_q   <= '0;
      ch_q     <= '0;
      valid_q  <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
      valid_q  <= valid_d;
      bad_q    <= bad_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    ch_d     = ch_q;
    valid_d  = valid_q;
    pop_c    = '0;
    bad_d    = bad_q | (bus_in_valid_i & ~ch_ok);
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          data_d   = win_data;
          ch_d     = win;
          valid_d  = 1'b1;
          state_d  = HOLD;
          rr_ptr_d = (32'(win) == NUM_CH - 1) ? '0 : win + CH_W'(1);
          for (int i = 0; i < int'(NUM_CH); i++) pop_c[i] = (CH_W'(i) == win);
        end
      end
      HOLD: begin
        if (bus_out_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop advances the FIFO on the same edge that captures its head; suppressed while in reset.
  assign ch_pop_o        = rst_i ? '0 : pop_c;
  assign bus_out_valid_o = valid_q;
  assign bus_out_data_o  = data_q;
  assign bus_out_ch_o    = ch_q;
  assign bad_ch_err_o    = bad_q;

  // Put path: full flag looked up only for in-range indices.
  always_comb begin
    ch_ok    = (32'(bus_in_ch_i) < NUM_CH);
    full_sel = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (CH_W'(i) == bus_in_ch_i) full_sel = ch_full_i[i];
    end
    bus_in_ready_o = ch_ok & ~full_sel;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ch_push_o[i] = bus_in_valid_i & bus_in_ready_o & (CH_W'(i) == bus_in_ch_i);
    end
  end

  assign ch_wdata_o = bus_in_data_i;

endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Self-checking bench for bus_xfer_arbiter: reference scoreboard of granted words
// plus directed scenarios for arbitration, backpressure, put routing and reset.
module tb_bus_xfer_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  get_req, empty, full, pop, push;
  logic [31:0] rd [3];
  logic [95:0] rdata;
  logic [31:0] wdata, out_data, in_data;
  logic        out_valid, out_ready, in_valid, in_ready, bad;
  logic [1:0]  out_ch, in_ch;

  int total = 0;
  int bad_cnt = 0;

  // Reference model state
  int          m_state;
  int          m_rr;
  logic        m_bad;
  logic [33:0] sb [$];
  int          grants [$];
  int          npop;
  logic [2:0]  obs_pop, obs_push;
  logic        obs_rdy;

  assign rdata = {rd[2], rd[1], rd[0]};

  bus_xfer_arbiter #(.DATA_W(32), .NUM_CH(3), .CH_W(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch_get_req_i(get_req), .ch_empty_i(empty), .ch_rdata_i(rdata),
    .ch_pop_o(pop), .ch_full_i(full), .ch_push_o(push), .ch_wdata_o(wdata),
    .bus_out_valid_o(out_valid), .bus_out_ready_i(out_ready),
    .bus_out_data_o(out_data), .bus_out_ch_o(out_ch),
    .bus_in_valid_i(in_valid), .bus_in_ch_i(in_ch), .bus_in_data_i(in_data),
    .bus_in_ready_o(in_ready), .bad_ch_err_o(bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // One clock: check outputs against the model, record expected words, advance the model.
  task automatic tick(input string tag);
    logic [2:0] elig, exp_pop, exp_push;
    logic       exp_rdy;
    int         w;
    #1;
    elig    = get_req & ~empty;
    exp_pop = '0;
    w       = -1;
    if (m_state == 0 && elig != 0) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_rr + k) % 3;
        if (w < 0 && elig[idx]) w = idx;
      end
      exp_pop[w] = 1'b1;
    end
    obs_pop  = pop;
    obs_push = push;
    obs_rdy  = in_ready;
    total++;
    if (pop !== exp_pop) begin
      bad_cnt++; $display("FAIL %s pop got=%b want=%b", tag, pop, exp_pop);
    end
    total++;
    if (out_valid !== (m_state == 1)) begin
      bad_cnt++; $display("FAIL %s valid got=%b want=%0d", tag, out_valid, m_state);
    end
    if (m_state == 1) begin
      total++;
      if (sb.size() == 0 || {out_ch, out_data} !== sb[0]) begin
        bad_cnt++;
        $display("FAIL %s word got=%0d:%h want=%h", tag, out_ch, out_data,
                 (sb.size() == 0) ? 34'h0 : sb[0]);
      end
    end
    exp_rdy  = (in_ch < 2'd3) && !full[in_ch];
    exp_push = '0;
    if (in_valid && exp_rdy) exp_push[in_ch] = 1'b1;
    total++;
    if (in_ready !== exp_rdy || push !== exp_push || wdata !== in_data) begin
      bad_cnt++;
      $display("FAIL %s put rdy=%b push=%b wdata=%h want rdy=%b push=%b wdata=%h",
               tag, in_ready, push, wdata, exp_rdy, exp_push, in_data);
    end
    total++;
    if (bad !== m_bad) begin
      bad_cnt++; $display("FAIL %s bad_ch_err got=%b want=%b", tag, bad, m_bad);
    end
    if (w >= 0) begin
      sb.push_back({2'(w), rd[w]});
      grants.push_back(w);
      npop++;
    end
    @(posedge clk);
    if (m_state == 0 && w >= 0) begin
      m_state = 1;
      m_rr    = (w + 1) % 3;
    end else if (m_state == 1 && out_ready) begin
      void'(sb.pop_front());
      m_state = 0;
    end
    if (in_valid && in_ch >= 2'd3) m_bad = 1'b1;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_state = 0; m_rr = 0; m_bad = 1'b0;
    sb.delete(); grants.delete(); npop = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; get_req = '0; empty = '1; full = '0; out_ready = 1'b0;
    in_valid = 1'b0; in_ch = '0; in_data = '0;
    rd[0] = '0; rd[1] = '0; rd[2] = '0;
    model_reset();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 2'd0 || pop !== 3'b000 || bad !== 1'b0) begin
      bad_cnt++;
      $display("FAIL reset valid=%b data=%h ch=%0d pop=%b bad=%b want all 0",
               out_valid, out_data, out_ch, pop, bad);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_get();
    get_req = 3'b010; empty = 3'b101; rd[1] = 32'hDEADBEEF; out_ready = 1'b1;
    tick("single_arb");
    total++;
    if (obs_pop !== 3'b010) begin
      bad_cnt++; $display("FAIL single_pop got=%b want=010", obs_pop);
    end
    get_req = 3'b000; empty = 3'b111;
    tick("single_hold");
    tick("single_drop");
    total++;
    if (out_valid !== 1'b0) begin
      bad_cnt++; $display("FAIL single_valid_drop got=%b want=0", out_valid);
    end
    // rr_ptr should now be 2: all eligible, channel 2 wins
    get_req = 3'b111; empty = 3'b000; rd[0] = 32'h0A; rd[2] = 32'h2A;
    tick("single_rr");
    total++;
    if (obs_pop !== 3'b100) begin
      bad_cnt++; $display("FAIL single_rr_next got=%b want=100", obs_pop);
    end
    get_req = '0; empty = '1;
    tick("single_rr_hold");
    tick("single_rr_idle");
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 2, 0, 1, 2};
    grants.delete();
    get_req = 3'b111; empty = 3'b000; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rd[0] = 32'h1000_0000 + 32'(c);
      rd[1] = 32'h2000_0000 + 32'(c);
      rd[2] = 32'h3000_0000 + 32'(c);
      tick("rr");
    end
    total++;
    if (grants.size() != 6) begin
      bad_cnt++; $display("FAIL rr_count got=%0d want=6", grants.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (grants[i] != exp_order[i]) begin
          bad_cnt++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, grants[i], exp_order[i]);
        end
      end
    end
    get_req = '0; empty = '1;
    tick("rr_tail");
  endtask

  task automatic test_backpressure();
    int p0;
    get_req = 3'b100; empty = 3'b011; rd[2] = 32'hC0FFEE02; out_ready = 1'b0;
    p0 = npop;
    tick("bp_arb");
    get_req = 3'b101; empty = 3'b000; rd[0] = 32'h0000C0DE;
    for (int c = 0; c < 5; c++) begin
      rd[2] = 32'hBAD0_0000 + 32'(c);
      tick("bp_hold");
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hC0FFEE02) begin
        bad_cnt++; $display("FAIL bp_stable valid=%b data=%h want 1/c0ffee02", out_valid, out_data);
      end
    end
    total++;
    if (npop - p0 != 1) begin
      bad_cnt++; $display("FAIL bp_single_pop got=%0d want=1", npop - p0);
    end
    out_ready = 1'b1;
    tick("bp_accept");
    tick("bp_next");
    total++;
    if (obs_pop !== 3'b001) begin
      bad_cnt++; $display("FAIL bp_ch0_served got=%b want=001", obs_pop);
    end
    get_req = '0; empty = '1;
    tick("bp_tail");
    tick("bp_idle");
  endtask

  task automatic test_put_full();
    in_valid = 1'b1; in_ch = 2'd1; in_data = 32'h5A5A_1234; full = 3'b010;
    tick("put_full");
    total++;
    if (obs_rdy !== 1'b0 || obs_push !== 3'b000) begin
      bad_cnt++; $display("FAIL put_stall rdy=%b push=%b want 0/000", obs_rdy, obs_push);
    end
    full = 3'b000;
    // concurrent get on the same channel
    get_req = 3'b010; empty = 3'b101; rd[1] = 32'h1111_2222;
    tick("put_go");
    total++;
    if (obs_rdy !== 1'b1 || obs_push !== 3'b010) begin
      bad_cnt++; $display("FAIL put_accept rdy=%b push=%b want 1/010", obs_rdy, obs_push);
    end
    get_req = '0; empty = '1; in_ch = 2'd2; in_data = 32'hFEED_0002;
    tick("put_ch2");
    in_valid = 1'b0;
    tick("put_idle");
  endtask

  task automatic test_bad_ch();
    in_valid = 1'b1; in_ch = 2'd3; in_data = 32'h0BAD_0BAD; full = 3'b000;
    tick("bad_req");
    total++;
    if (obs_rdy !== 1'b0 || obs_push !== 3'b000 || bad !== 1'b1) begin
      bad_cnt++; $display("FAIL bad_set rdy=%b push=%b err=%b want 0/000/1", obs_rdy, obs_push, bad);
    end
    in_valid = 1'b0; in_ch = 2'd0;
    for (int c = 0; c < 3; c++) tick("bad_sticky");
    total++;
    if (bad !== 1'b1) begin
      bad_cnt++; $display("FAIL bad_sticky got=%b want=1", bad);
    end
  endtask

  task automatic test_reset_hold();
    get_req = 3'b010; empty = 3'b101; rd[1] = 32'h7777_0001; out_ready = 1'b0;
    tick("rh_arb");
    tick("rh_hold");
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || pop !== 3'b000 || bad !== 1'b0) begin
      bad_cnt++; $display("FAIL reset_mid_hold valid=%b pop=%b err=%b want 0/000/0", out_valid, pop, bad);
    end
    model_reset();
    get_req = 3'b111; empty = 3'b000; rd[0] = 32'hAAAA_0000; rd[1] = 32'hAAAA_0001; rd[2] = 32'hAAAA_0002;
    @(posedge clk);
    #1;
    total++;
    if (pop !== 3'b000) begin
      bad_cnt++; $display("FAIL reset_no_pop got=%b want=000", pop);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick("rh_first");
    total++;
    if (obs_pop !== 3'b001) begin
      bad_cnt++; $display("FAIL reset_ch0_first got=%b want=001", obs_pop);
    end
    get_req = '0; empty = '1;
    tick("rh_tail");
    tick("rh_idle");
  endtask

  initial begin
    test_reset();
    test_single_get();
    test_round_robin();
    test_backpressure();
    test_put_full();
    test_bad_ch();
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
